// File: rtl/adex_neuron_array.sv
// Time-multiplexed AdEx neuron array: one shared datapath updates one
// channel per enabled cycle round-robin; spike/above_vt/state/frame_done.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   en         : update/advance enable
//   current    : packed per-channel input current, ch k at [k*WIDTH +: WIDTH]
//   sel        : channel chosen for membrane readback
//   spike      : one-cycle spike pulse per channel
//   above_vt   : registered V[k] >= V_T
//   state      : registered V[sel]
//   frame_done : pulse after channel N_CH-1 has been updated
module adex_neuron_array #(
  parameter int WIDTH       = 8,
  parameter int N_CH        = 4,
  parameter int V_T         = 128,
  parameter int V_PEAK      = 224,
  parameter int V_RESET     = 16,
  parameter int LEAK_SHIFT  = 3,
  parameter int EXP_SHIFT   = 4,
  parameter int TAU_W_SHIFT = 4,
  parameter int B           = 16,
  parameter int REFRACT     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_CH*WIDTH-1:0]   current,
  input  logic [$clog2(N_CH)-1:0] sel,
  output logic [N_CH-1:0]         spike,
  output logic [N_CH-1:0]         above_vt,
  output logic [WIDTH-1:0]        state,
  output logic                    frame_done
);

  localparam int CW = $clog2(N_CH);
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int XW = WIDTH + 3;

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t          L_MAX  = '1;
  localparam word_t          L_VT   = word_t'(V_T);
  localparam word_t          L_PEAK = word_t'(V_PEAK);
  localparam word_t          L_VRST = word_t'(V_RESET);
  localparam word_t          L_B    = word_t'(B);
  localparam word_t          L_NW   = word_t'(WIDTH);
  localparam logic [RW-1:0]  L_REF  = RW'(REFRACT);
  localparam logic [CW-1:0]  L_LAST = CW'(N_CH - 1);

  word_t          r_v [N_CH];
  word_t          r_w [N_CH];
  logic [RW-1:0]  r_r [N_CH];
  logic [CW-1:0]  r_ch;
  logic [N_CH-1:0] r_spike;
  logic [N_CH-1:0] r_above;
  word_t          r_state;
  logic           r_frame;

  word_t                w_v;
  word_t                w_w;
  word_t                w_i;
  logic [RW-1:0]        w_r;
  word_t                w_wd;
  word_t                w_n;
  word_t                w_e;
  logic signed [XW-1:0] w_x;
  word_t                w_vn;
  logic [WIDTH:0]       w_wb;
  logic                 w_refr;
  logic                 w_fire;
  word_t                w_vnext;
  word_t                w_wnext;
  logic [RW-1:0]        w_rnext;

  assign w_v = r_v[r_ch];
  assign w_w = r_w[r_ch];
  assign w_r = r_r[r_ch];
  assign w_i = current[r_ch*WIDTH +: WIDTH];

  always_comb begin
    w_wd = w_w - (w_w >> TAU_W_SHIFT);
    w_n  = (w_v - L_VT) >> EXP_SHIFT;
    w_e  = '0;
    if (w_v >= L_VT) begin
      w_e = (w_n >= L_NW) ? L_MAX : (word_t'(1) << w_n);
    end
    // 3 guard bits hold the full range; wraparound gives two's complement
    w_x = $signed({3'b000, w_v}
                - {3'b000, w_v >> LEAK_SHIFT}
                + {3'b000, w_i}
                + {3'b000, w_e}
                - {3'b000, w_wd});
    if (w_x[XW-1]) begin
      w_vn = '0;
    end else if (w_x[XW-2:WIDTH] != '0) begin
      w_vn = L_MAX;
    end else begin
      w_vn = w_x[WIDTH-1:0];
    end
    w_refr  = (w_r != '0);
    w_fire  = !w_refr && (w_vn >= L_PEAK);
    w_wb    = {1'b0, w_wd} + {1'b0, L_B};
    w_vnext = w_vn;
    w_wnext = w_wd;
    w_rnext = '0;
    unique case (1'b1)
      w_refr: begin
        w_vnext = L_VRST;
        w_rnext = w_r - RW'(1);
      end
      w_fire: begin
        w_vnext = L_VRST;
        w_wnext = w_wb[WIDTH] ? L_MAX : w_wb[WIDTH-1:0];
        w_rnext = L_REF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        r_v[k] <= '0;
        r_w[k] <= '0;
        r_r[k] <= '0;
      end
      r_ch    <= '0;
      r_spike <= '0;
      r_above <= '0;
      r_state <= '0;
      r_frame <= 1'b0;
    end else begin
      r_spike <= '0;
      r_frame <= 1'b0;
      r_state <= r_v[sel];
      if (en) begin
        r_v[r_ch]     <= w_vnext;
        r_w[r_ch]     <= w_wnext;
        r_r[r_ch]     <= w_rnext;
        r_above[r_ch] <= (w_vnext >= L_VT);
        r_spike[r_ch] <= w_fire;
        r_frame       <= (r_ch == L_LAST);
        r_ch          <= r_ch + CW'(1);
      end
    end
  end

  assign spike      = r_spike;
  assign above_vt   = r_above;
  assign state      = r_state;
  assign frame_done = r_frame;

endmodule

// File: tb/tb_adex_neuron_array.sv
// Self-checking bench for adex_neuron_array: directed vectors with
// hand-computed values plus a per-channel reference model.
module tb_adex_neuron_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] current;
  logic [1:0]  sel;
  logic [3:0]  spike;
  logic [3:0]  above_vt;
  logic [7:0]  state;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;

  int   mv [4];
  int   mw [4];
  int   mr [4];
  int   mch;
  logic [3:0] m_above;

  adex_neuron_array dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .current(current),
    .sel(sel),
    .spike(spike),
    .above_vt(above_vt),
    .state(state),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat8(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 0;
      mw[k] = 0;
      mr[k] = 0;
    end
    mch = 0;
    m_above = '0;
  endtask

  task automatic tick();
    int k, wd, e, n, x, pre;
    logic [3:0] es;
    logic efd;
    pre = mv[sel];
    es  = '0;
    efd = 1'b0;
    if (en && rst_n) begin
      k  = mch;
      wd = mw[k] - (mw[k] >> 4);
      if (mr[k] > 0) begin
        mv[k] = 16;
        mw[k] = wd;
        mr[k] = mr[k] - 1;
      end else begin
        e = 0;
        if (mv[k] >= 128) begin
          n = (mv[k] - 128) >> 4;
          e = (n >= 8) ? 255 : (1 << n);
        end
        x = sat8(mv[k] - (mv[k] >> 3) + int'(current[k*8 +: 8]) + e - wd);
        if (x >= 224) begin
          es[k] = 1'b1;
          mv[k] = 16;
          mw[k] = (wd + 16 > 255) ? 255 : wd + 16;
          mr[k] = 2;
        end else begin
          mv[k] = x;
          mw[k] = wd;
        end
      end
      m_above[k] = (mv[k] >= 128);
      efd = (k == 3);
      mch = (mch + 1) % 4;
    end
    @(posedge clk);
    #1;
    check_eq("spike", spike, es);
    check_eq("frame_done", frame_done, efd);
    check_eq("above_vt", above_vt, m_above);
    check_eq("state", state, pre);
  endtask

  task automatic frame(output logic [3:0] sp, output int fd);
    sp = '0;
    fd = 0;
    repeat (4) begin
      tick();
      sp |= spike;
      fd += frame_done;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sp;
    int fd;
    int gap;
    int sub_exp [4] = '{10, 19, 27, 34};
    int exp_v   [12] = '{30, 57, 80, 100, 118, 134, 149, 163, 177, 193, 215, 16};
    int iso_v   [4] = '{5, 20, 40, 60};

    rst_n   = 1'b0;
    en      = 1'b0;
    current = '0;
    sel     = '0;
    model_reset();
    tick();
    tick();
    check_eq("rst_spike", spike, 0);
    check_eq("rst_above", above_vt, 0);
    check_eq("rst_state", state, 0);
    check_eq("rst_fd", frame_done, 0);

    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) begin
      frame(sp, fd);
      check_eq("idle_fd_count", fd, 1);
      check_eq("idle_spikes", sp, 0);
      check_eq("idle_state", state, 0);
    end

    current[7:0] = 8'd10;
    for (int i = 0; i < 4; i++) begin
      frame(sp, fd);
      check_eq("sub_v0", state, sub_exp[i]);
      check_eq("sub_above0", above_vt[0], 0);
      check_eq("sub_spikes", sp, 0);
    end

    current[15:8] = 8'd255;
    sel = 2'd1;
    frame(sp, fd);
    check_eq("sat_spike1", sp[1], 1);
    check_eq("sat_v1", state, 16);
    for (int i = 0; i < 2; i++) begin
      frame(sp, fd);
      check_eq("refr_nospike1", sp[1], 0);
      check_eq("refr_v1", state, 16);
    end
    frame(sp, fd);
    check_eq("resp_spike1", sp[1], 1);
    check_eq("resp_v1", state, 16);
    current[15:8] = 8'd0;

    current[23:16] = 8'd30;
    sel = 2'd2;
    for (int i = 0; i < 12; i++) begin
      frame(sp, fd);
      check_eq("exp_v2", state, exp_v[i]);
      check_eq("exp_above2", above_vt[2], (exp_v[i] >= 128) ? 1 : 0);
      check_eq("exp_spike2", sp[2], (i == 11) ? 1 : 0);
    end
    current[23:16] = 8'd0;

    tick();
    tick();
    en  = 1'b0;
    gap = 0;
    repeat (5) begin
      tick();
      gap += frame_done + int'(spike != 0);
    end
    check_eq("gate_quiet", gap, 0);
    en = 1'b1;
    tick();
    check_eq("gate_fd_early", frame_done, 0);
    tick();
    check_eq("gate_fd_resume", frame_done, 1);

    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_state", state, 0);
    check_eq("mid_rst_above", above_vt, 0);
    check_eq("mid_rst_spike", spike, 0);
    check_eq("mid_rst_fd", frame_done, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    current = {8'd60, 8'd40, 8'd20, 8'd5};
    frame(sp, fd);
    en      = 1'b0;
    current = '0;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      tick();
      check_eq("iso_sweep", state, iso_v[k]);
    end

    en      = 1'b1;
    current = {8'd90, 8'd7, 8'd200, 8'd33};
    for (int i = 0; i < 6; i++) begin
      sel = 2'(i % 4);
      frame(sp, fd);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
